block_scan_sequencer: RTL

- Sequences one full-frame accumulation pass for the bank of edge/corner colour-averaging blocks.
- Accepts a GRB pixel stream and tracks the 1-based row/column position over a ROWS x COLS frame.
- Drives the shared row_now/col_now/GRBdata/data_rd bus of the accumulators and clears them before each frame.
- After the frame, reads each block's result through a select mux and hands it to the LED output stage over a valid/ready handshake.

---
 rtl/block_scan_sequencer_pkg.sv | 31 +++
 rtl/block_scan_sequencer_pos_counter.sv | 61 ++++++
 rtl/block_scan_sequencer.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/block_scan_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// block_scan_sequencer_pkg
// Shared definitions for the frame scan sequencer and the colour-averaging
// accumulator blocks it drives: default frame geometry, bus widths and the
// sequencer state encoding.
// -----------------------------------------------------------------------------
package block_scan_sequencer_pkg;

    // Default frame geometry, also used by the accumulator blocks
    localparam int COLS_DEF       = 96;
    localparam int ROWS_DEF       = 53;
    localparam int NBLK_DEF       = 4;
    localparam int SELW_DEF       = 2;
    localparam int SETTLE_CYC_DEF = 2;

    // Row/column bus width (1-based positions up to 127)
    localparam int POS_W = 7;
    // Pixel / block result width, {G,R,B}
    localparam int GRB_W = 24;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CLEAR     = 3'd1,
        ST_LOAD      = 3'd2,
        ST_STROBE    = 3'd3,
        ST_SETTLE    = 3'd4,
        ST_DRAIN_SEL = 3'd5,
        ST_DRAIN_OUT = 3'd6
    } state_e;

endpackage

// File: rtl/block_scan_sequencer_pos_counter.sv
// -----------------------------------------------------------------------------
// scan_pos_counter
// 1-based column/row position counter for a ROWS x COLS raster.
//   clk, rst   : clock, synchronous active-low reset (position -> (1,1))
//   clr        : restart at (1,1)
//   adv        : step to the next pixel (col+1, or col=1,row+1 at row end)
//   row, col   : current 1-based position
//   first      : position is (1,1)
//   last       : position is (ROWS,COLS)
// -----------------------------------------------------------------------------
module scan_pos_counter
    import block_scan_sequencer_pkg::*;
#(
    parameter int COLS = COLS_DEF,
    parameter int ROWS = ROWS_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             adv,
    output logic [POS_W-1:0] row,
    output logic [POS_W-1:0] col,
    output logic             first,
    output logic             last
);

    logic [POS_W-1:0] row_q, row_d;
    logic [POS_W-1:0] col_q, col_d;

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clr) begin
            row_d = POS_W'(1);
            col_d = POS_W'(1);
        end else if (adv) begin
            if (col_q == POS_W'(COLS)) begin
                col_d = POS_W'(1);
                row_d = row_q + POS_W'(1);
            end else begin
                col_d = col_q + POS_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            row_q <= POS_W'(1);
            col_q <= POS_W'(1);
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row   = row_q;
    assign col   = col_q;
    assign first = (row_q == POS_W'(1)) && (col_q == POS_W'(1));
    assign last  = (row_q == POS_W'(ROWS)) && (col_q == POS_W'(COLS));

endmodule

// File: rtl/block_scan_sequencer.sv
// -----------------------------------------------------------------------------
// block_scan_sequencer
// Runs one accumulation pass per frame for the bank of colour-averaging
// blocks: clears them, feeds every pixel of a ROWS x COLS GRB stream on the
// shared row_now/col_now/grb_out/data_rd bus, then reads each block result
// through the external acc_sel mux and hands it to the LED stage.
//   clk, rst            : clock, synchronous active-low reset
//   pix_valid/pix_sof/pix_grb/pix_ready : pixel stream (sof = row 1, col 1)
//   grb_out/row_now/col_now/data_rd      : accumulator bus, data_rd = strobe
//   acc_rst             : active-low accumulator clear
//   acc_sel/acc_result  : block result select and selected result
//   led_valid/led_ready/led_grb/led_idx  : result handshake to LED stage
//   frame_done          : pulse after the last result handshake
//   err_sof             : pulse on a pix_sof away from (1,1)
//   busy                : sequencer not idle
// -----------------------------------------------------------------------------
module block_scan_sequencer
    import block_scan_sequencer_pkg::*;
#(
    parameter int COLS       = COLS_DEF,
    parameter int ROWS       = ROWS_DEF,
    parameter int NBLK       = NBLK_DEF,
    parameter int SELW       = SELW_DEF,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_valid,
    input  logic             pix_sof,
    input  logic [GRB_W-1:0] pix_grb,
    output logic             pix_ready,
    output logic [GRB_W-1:0] grb_out,
    output logic [POS_W-1:0] row_now,
    output logic [POS_W-1:0] col_now,
    output logic             data_rd,
    output logic             acc_rst,
    output logic [SELW-1:0]  acc_sel,
    input  logic [GRB_W-1:0] acc_result,
    output logic             led_valid,
    input  logic             led_ready,
    output logic [GRB_W-1:0] led_grb,
    output logic [SELW-1:0]  led_idx,
    output logic             frame_done,
    output logic             err_sof,
    output logic             busy
);

    localparam int SETTLE_W = $clog2(SETTLE_CYC + 1) + 1;

    state_e               state_q, state_d;
    logic [GRB_W-1:0]     grb_out_q, grb_out_d;
    logic [POS_W-1:0]     row_now_q, row_now_d;
    logic [POS_W-1:0]     col_now_q, col_now_d;
    logic                 data_rd_q, data_rd_d;
    logic                 acc_rst_q, acc_rst_d;
    logic [SELW-1:0]      acc_sel_q, acc_sel_d;
    logic                 led_valid_q, led_valid_d;
    logic [GRB_W-1:0]     led_grb_q, led_grb_d;
    logic [SELW-1:0]      led_idx_q, led_idx_d;
    logic                 frame_done_q, frame_done_d;
    logic                 err_sof_q, err_sof_d;
    logic                 busy_q, busy_d;
    logic [SETTLE_W-1:0]  settle_q, settle_d;

    logic [POS_W-1:0]     pos_row, pos_col;
    logic                 pos_first, pos_last;
    logic                 sof_restart;
    logic                 pix_ready_c;
    logic                 accept;

    scan_pos_counter #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_pos (
        .clk   (clk),
        .rst   (rst),
        .clr   (state_q == ST_CLEAR),
        .adv   (state_q == ST_STROBE),
        .row   (pos_row),
        .col   (pos_col),
        .first (pos_first),
        .last  (pos_last)
    );

    // A start-of-frame anywhere but (1,1) restarts the frame; that pixel is
    // refused here and re-offered by the source after the CLEAR cycle.
    assign sof_restart = pix_valid && pix_sof && !pos_first;

    // pix_ready has to react to pix_sof in the same cycle, so it is the one
    // combinational output. It is masked during reset so nothing is consumed.
    assign pix_ready_c = rst && (state_q == ST_LOAD) && !sof_restart;
    assign accept      = pix_valid && pix_ready_c;

    always_comb begin
        state_d      = state_q;
        grb_out_d    = grb_out_q;
        row_now_d    = row_now_q;
        col_now_d    = col_now_q;
        acc_sel_d    = acc_sel_q;
        led_valid_d  = led_valid_q;
        led_grb_d    = led_grb_q;
        led_idx_d    = led_idx_q;
        settle_d     = settle_q;
        err_sof_d    = 1'b0;
        frame_done_d = 1'b0;
        // data_rd is the registered image of STROBE, so it rises one clock
        // after grb_out/row_now/col_now change and the accumulators see a
        // bus that has been stable for a full cycle at the rising edge.
        data_rd_d    = (state_q == ST_STROBE);

        case (state_q)
            ST_IDLE: begin
                // The sof pixel is left waiting at the source until LOAD.
                if (pix_valid && pix_sof) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (sof_restart) begin
                    err_sof_d = 1'b1;
                    state_d   = ST_CLEAR;
                end else if (accept) begin
                    grb_out_d = pix_grb;
                    row_now_d = pos_row;
                    col_now_d = pos_col;
                    state_d   = ST_STROBE;
                end
            end
            ST_STROBE: begin
                if (pos_last) begin
                    // One extra SETTLE cycle covers the trailing data_rd
                    // pulse, leaving SETTLE_CYC quiet cycles before the reads.
                    settle_d = SETTLE_W'(SETTLE_CYC);
                    state_d  = ST_SETTLE;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_SETTLE: begin
                if (settle_q == '0) begin
                    acc_sel_d = '0;
                    state_d   = ST_DRAIN_SEL;
                end else begin
                    settle_d = settle_q - SETTLE_W'(1);
                end
            end
            ST_DRAIN_SEL: begin
                led_grb_d   = acc_result;
                led_idx_d   = acc_sel_q;
                led_valid_d = 1'b1;
                state_d     = ST_DRAIN_OUT;
            end
            ST_DRAIN_OUT: begin
                if (led_ready) begin
                    led_valid_d = 1'b0;
                    if (acc_sel_q == SELW'(NBLK - 1)) begin
                        frame_done_d = 1'b1;
                        state_d      = ST_IDLE;
                    end else begin
                        acc_sel_d = acc_sel_q + SELW'(1);
                        state_d   = ST_DRAIN_SEL;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        acc_rst_d = (state_d != ST_CLEAR);
        busy_d    = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            grb_out_q    <= '0;
            row_now_q    <= '0;
            col_now_q    <= '0;
            data_rd_q    <= 1'b0;
            acc_rst_q    <= 1'b0;
            acc_sel_q    <= '0;
            led_valid_q  <= 1'b0;
            led_grb_q    <= '0;
            led_idx_q    <= '0;
            frame_done_q <= 1'b0;
            err_sof_q    <= 1'b0;
            busy_q       <= 1'b0;
            settle_q     <= '0;
        end else begin
            state_q      <= state_d;
            grb_out_q    <= grb_out_d;
            row_now_q    <= row_now_d;
            col_now_q    <= col_now_d;
            data_rd_q    <= data_rd_d;
            acc_rst_q    <= acc_rst_d;
            acc_sel_q    <= acc_sel_d;
            led_valid_q  <= led_valid_d;
            led_grb_q    <= led_grb_d;
            led_idx_q    <= led_idx_d;
            frame_done_q <= frame_done_d;
            err_sof_q    <= err_sof_d;
            busy_q       <= busy_d;
            settle_q     <= settle_d;
        end
    end

    assign pix_ready  = pix_ready_c;
    assign grb_out    = grb_out_q;
    assign row_now    = row_now_q;
    assign col_now    = col_now_q;
    assign data_rd    = data_rd_q;
    assign acc_rst    = acc_rst_q;
    assign acc_sel    = acc_sel_q;
    assign led_valid  = led_valid_q;
    assign led_grb    = led_grb_q;
    assign led_idx    = led_idx_q;
    assign frame_done = frame_done_q;
    assign err_sof    = err_sof_q;
    assign busy       = busy_q;

endmodule
